// File: rtl/mips16_ctx_pkg.sv
// Shared types and constants for the MIPS16 register-file context save/restore engine.
package mips16_ctx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSave,
    StSaveCs,
    StRestore,
    StRestoreCs,
    StDone
  } ctx_state_t;

  localparam int unsigned NUM_REGS   = 8;
  localparam int unsigned SAVE_BEATS = NUM_REGS / 2;
  localparam logic [15:0] CS_PAD     = 16'h0000;

endpackage

// File: rtl/reg_context_engine.sv
// Whole-register-file context engine: streams registers out as pairs plus an XOR checksum beat,
// or writes them back from a word stream and verifies a trailing checksum word.
module reg_context_engine
  import mips16_ctx_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  save_req,
  input  logic                  restore_req,
  output logic                  busy,
  output logic                  done,
  output logic                  cs_err,
  output logic                  sv_valid,
  input  logic                  sv_ready,
  output logic [2*DATA_W-1:0]   sv_data,
  input  logic                  rs_valid,
  output logic                  rs_ready,
  input  logic [DATA_W-1:0]     rs_data,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0]     reg_write_data,
  output logic [REG_ADDR_W-1:0] reg_read_addr_1,
  input  logic [DATA_W-1:0]     reg_read_data_1,
  input  logic [DATA_W-1:0]     reg_read_data_2,
  output logic [REG_ADDR_W-1:0] reg_read_addr_2
);

  ctx_state_t            state_q, state_d;
  logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]     cs_q, cs_d;
  logic                  cs_err_q, cs_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      cs_q     <= '0;
      cs_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cs_q     <= cs_d;
      cs_err_q <= cs_err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cs_d            = cs_q;
    cs_err_d        = cs_err_q;
    done            = 1'b0;
    sv_valid        = 1'b0;
    sv_data         = '0;
    rs_ready        = 1'b0;
    reg_write_en    = 1'b0;
    reg_write_dest  = '0;
    reg_write_data  = '0;
    reg_read_addr_1 = REG_ADDR_W'(0);
    reg_read_addr_2 = REG_ADDR_W'(1);

    unique case (state_q)
      StIdle: begin
        // Save has priority when both requests arrive together.
        if (save_req || restore_req) begin
          state_d  = save_req ? StSave : StRestore;
          cnt_d    = '0;
          cs_d     = '0;
          cs_err_d = 1'b0;
        end
      end
      StSave: begin
        sv_valid        = 1'b1;
        reg_read_addr_1 = {cnt_q[REG_ADDR_W-2:0], 1'b0};
        reg_read_addr_2 = {cnt_q[REG_ADDR_W-2:0], 1'b1};
        sv_data         = {reg_read_data_2, reg_read_data_1};
        if (sv_ready) begin
          cs_d  = cs_q ^ reg_read_data_1 ^ reg_read_data_2;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == REG_ADDR_W'(SAVE_BEATS - 1)) state_d = StSaveCs;
        end
      end
      StSaveCs: begin
        sv_valid = 1'b1;
        sv_data  = {DATA_W'(CS_PAD), cs_q};
        if (sv_ready) state_d = StDone;
      end
      StRestore: begin
        rs_ready       = 1'b1;
        reg_write_dest = cnt_q;
        reg_write_data = rs_data;
        if (rs_valid) begin
          reg_write_en = 1'b1;
          cs_d         = cs_q ^ rs_data;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == REG_ADDR_W'(NUM_REGS - 1)) state_d = StRestoreCs;
        end
      end
      StRestoreCs: begin
        rs_ready = 1'b1;
        if (rs_valid) begin
          cs_err_d = (rs_data != cs_q);
          state_d  = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy   = (state_q != StIdle);
  assign cs_err = cs_err_q;

endmodule

// File: tb/tb_reg_context_engine.sv
// Directed bench for reg_context_engine with a behavioural 8x16 register file model.
module tb_reg_context_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        save_req, restore_req;
  logic        busy, done, cs_err;
  logic        sv_valid, sv_ready;
  logic [31:0] sv_data;
  logic        rs_valid, rs_ready;
  logic [15:0] rs_data;
  logic        reg_write_en;
  logic [2:0]  reg_write_dest, reg_read_addr_1, reg_read_addr_2;
  logic [15:0] reg_write_data, reg_read_data_1, reg_read_data_2;

  logic [15:0] rf [8];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] exp_beats [5];
  int          b;
  int          w;

  always #5 clk = ~clk;

  always @(posedge clk) if (reg_write_en) rf[reg_write_dest] <= reg_write_data;
  assign reg_read_data_1 = rf[reg_read_addr_1];
  assign reg_read_data_2 = rf[reg_read_addr_2];

  reg_context_engine #(.DATA_W(16), .REG_ADDR_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .save_req       (save_req),
    .restore_req    (restore_req),
    .busy           (busy),
    .done           (done),
    .cs_err         (cs_err),
    .sv_valid       (sv_valid),
    .sv_ready       (sv_ready),
    .sv_data        (sv_data),
    .rs_valid       (rs_valid),
    .rs_ready       (rs_ready),
    .rs_data        (rs_data),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .reg_read_addr_1(reg_read_addr_1),
    .reg_read_data_1(reg_read_data_1),
    .reg_read_data_2(reg_read_data_2),
    .reg_read_addr_2(reg_read_addr_2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; save_req = 1'b0; restore_req = 1'b0;
    sv_ready = 1'b0; rs_valid = 1'b0; rs_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs_err", cs_err, 0);
    chk("rst_sv_valid", sv_valid, 0);
    chk("rst_rs_ready", rs_ready, 0);
    chk("rst_wen", reg_write_en, 0);
    chk("rst_sv_data", sv_data, 0);
    chk("idle_raddr1", reg_read_addr_1, 0);
    chk("idle_raddr2", reg_read_addr_2, 1);

    // Save of preloaded 0x1000+i, ready held high
    for (int i = 0; i < 8; i++) rf[i] = 16'h1000 + 16'(i);
    exp_beats[0] = 32'h1001_1000; exp_beats[1] = 32'h1003_1002;
    exp_beats[2] = 32'h1005_1004; exp_beats[3] = 32'h1007_1006;
    exp_beats[4] = 32'h0000_0000;
    save_req = 1'b1; sv_ready = 1'b1;
    tick();
    save_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("save1_valid%0d", i), sv_valid, 1);
      chk($sformatf("save1_beat%0d", i), sv_data, exp_beats[i]);
      chk($sformatf("save1_done%0d", i), done, 0);
      tick();
    end
    chk("save1_done", done, 1);
    chk("save1_cs_err", cs_err, 0);
    chk("save1_sv_valid_done", sv_valid, 0);
    tick();
    chk("save1_idle_busy", busy, 0);
    chk("save1_idle_done", done, 0);

    // Restore 0xA000+i with good checksum
    restore_req = 1'b1; rs_valid = 1'b1;
    tick();
    restore_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rs_data = 16'hA000 + 16'(i);
      #1;
      chk($sformatf("rst1_ready%0d", i), rs_ready, 1);
      chk($sformatf("rst1_wen%0d", i), reg_write_en, 1);
      chk($sformatf("rst1_dest%0d", i), reg_write_dest, i);
      tick();
    end
    rs_data = 16'h0000;
    #1;
    chk("rst1_cs_wen", reg_write_en, 0);
    chk("rst1_cs_ready", rs_ready, 1);
    tick();
    rs_valid = 1'b0;
    chk("rst1_done", done, 1);
    chk("rst1_cs_err", cs_err, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst1_rf%0d", i), rf[i], 16'hA000 + 16'(i));
    tick();
    chk("rst1_idle_done", done, 0);

    // Same restore, bad checksum word
    restore_req = 1'b1; rs_valid = 1'b1;
    tick();
    restore_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rs_data = 16'hA000 + 16'(i);
      tick();
    end
    rs_data = 16'hFFFF;
    tick();
    rs_valid = 1'b0;
    chk("rst2_done", done, 1);
    chk("rst2_cs_err", cs_err, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("rst2_rf%0d", i), rf[i], 16'hA000 + 16'(i));
    tick();
    chk("rst2_cs_err_hold", cs_err, 1);

    // Save with ready toggling every cycle
    exp_beats[0] = 32'hA001_A000; exp_beats[1] = 32'hA003_A002;
    exp_beats[2] = 32'hA005_A004; exp_beats[3] = 32'hA007_A006;
    exp_beats[4] = 32'h0000_0000;
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    chk("save2_cs_err_clr", cs_err, 0);
    b = 0;
    for (int cyc = 0; cyc < 20 && b < 5; cyc++) begin
      sv_ready = cyc[0];
      #1;
      chk($sformatf("save2_valid_c%0d", cyc), sv_valid, 1);
      chk($sformatf("save2_beat_c%0d", cyc), sv_data, exp_beats[b]);
      if (sv_ready) b++;
      tick();
    end
    chk("save2_beat_count", b, 5);
    chk("save2_done", done, 1);
    chk("save2_cs_err", cs_err, 0);
    tick();

    // Restore with valid gaps, reset after the third word
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    w = 0;
    for (int cyc = 0; cyc < 20 && w < 3; cyc++) begin
      rs_valid = ~cyc[0];
      rs_data  = 16'h5550 + 16'(w);
      #1;
      chk($sformatf("rst3_wen_c%0d", cyc), reg_write_en, rs_valid);
      chk($sformatf("rst3_done_c%0d", cyc), done, 0);
      if (rs_valid) w++;
      tick();
    end
    chk("rst3_word_count", w, 3);
    rs_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst3_busy", busy, 0);
    chk("rst3_done", done, 0);
    chk("rst3_rs_ready", rs_ready, 0);
    for (int i = 0; i < 3; i++) chk($sformatf("rst3_rf%0d", i), rf[i], 16'h5550 + 16'(i));
    for (int i = 3; i < 8; i++) chk($sformatf("rst3_rf%0d", i), rf[i], 16'hA000 + 16'(i));

    // Simultaneous requests: save wins; restore_req mid-save ignored
    exp_beats[0] = 32'h5551_5550; exp_beats[1] = 32'hA003_5552;
    exp_beats[2] = 32'hA005_A004; exp_beats[3] = 32'hA007_A006;
    exp_beats[4] = 32'h0000_F550;
    save_req = 1'b1; restore_req = 1'b1; sv_ready = 1'b1;
    tick();
    save_req = 1'b0; restore_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      restore_req = (i == 2);
      #1;
      chk($sformatf("save3_beat%0d", i), sv_data, exp_beats[i]);
      chk($sformatf("save3_wen%0d", i), reg_write_en, 0);
      chk($sformatf("save3_rs_ready%0d", i), rs_ready, 0);
      tick();
    end
    restore_req = 1'b0;
    chk("save3_done", done, 1);
    chk("save3_wen_done", reg_write_en, 0);
    tick();
    tick();
    chk("save3_no_queued_op", busy, 0);
    chk("save3_rf_intact", rf[0], 16'h5550);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/reg_context_engine.md
Name: reg_context_engine

Overview:
- Bus master for the register_file write port and both read ports; performs whole-file context save and restore for the MIPS16 core (debug, interrupt context switch).
- Save: reads all registers and streams them out as register pairs, then a checksum beat.
- Restore: accepts a 16-bit word stream, writes the registers in order, then checks a trailing checksum word.
- Sits between the register file and a debug/context-memory streaming port.

Parameters:
- DATA_W, 16, register width.
- REG_ADDR_W, 3, register address width; NUM_REGS = 2**REG_ADDR_W (8).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- save_req  in  1  start save; sampled only in IDLE
- restore_req  in  1  start restore; sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when an operation completes
- cs_err  out  1  restore checksum mismatch; valid while done=1
- sv_valid  out  1  save stream valid
- sv_ready  in  1  save stream ready
- sv_data  out  2*DATA_W  save beat
- rs_valid  in  1  restore stream valid
- rs_ready  out  1  restore stream ready
- rs_data  in  DATA_W  restore word
- reg_write_en  out  1  register file write enable
- reg_write_dest  out  REG_ADDR_W  write address
- reg_write_data  out  DATA_W  write data
- reg_read_addr_1  out  REG_ADDR_W  read address, port 1
- reg_read_data_1  in  DATA_W  read data, port 1 (combinational read)
- reg_read_data_2  in  DATA_W  read data, port 2 (combinational read)
- reg_read_addr_2  out  REG_ADDR_W  read address, port 2

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE, counter 0, checksum 0.
- Outputs after reset: busy, done, cs_err, sv_valid, rs_ready, reg_write_en all 0; sv_data 0.
- Register file contents are not touched by reset. A reset mid-operation abandons it; registers already written keep their values. No done pulse.
- States: IDLE, SAVE, SAVE_CS, RESTORE, RESTORE_CS, DONE.
- IDLE:
  - save_req -> SAVE; else restore_req -> RESTORE. save_req wins if both are high.
  - Counter and checksum are cleared on entry to either operation.
- SAVE:
  - pair index k = 0..3; reg_read_addr_1 = 2k, reg_read_addr_2 = 2k+1.
  - sv_valid = 1; sv_data = {reg_read_data_2, reg_read_data_1}.
  - On sv_valid & sv_ready: checksum ^= both words; k++.
  - After the k=3 handshake -> SAVE_CS.
  - Without ready, sv_valid and sv_data are held stable and addresses do not change.
  - Beats are back-to-back at one beat per cycle when ready is held high.
- SAVE_CS:
  - sv_valid = 1; sv_data = {16'h0000, checksum}.
  - Handshake -> DONE.
- RESTORE:
  - rs_ready = 1; index r = 0..7.
  - reg_write_en = rs_valid & rs_ready (combinational); reg_write_dest = r; reg_write_data = rs_data.
  - The write lands at the same posedge as the handshake. Checksum ^= rs_data.
  - After the r=7 handshake -> RESTORE_CS.
  - rs_valid low: no write, nothing advances.
- RESTORE_CS:
  - rs_ready = 1, no write.
  - On handshake: cs_err register <= (rs_data != checksum); -> DONE.
- DONE: done = 1 for exactly one cycle -> IDLE. cs_err holds until the next operation starts; it is 0 after any save.
- Read addresses in IDLE, RESTORE and RESTORE_CS: 0 and 1. reg_write_en is 0 outside RESTORE.
- Requests arriving while busy are ignored (not queued).
- Latency with no stalls:
  - Save = 1 (start) + 5 beats + 1 DONE.
  - Restore = 1 + 9 words + 1 DONE.
- Checksum: 16-bit XOR; no carries, no width growth.

Decomposition:
- Shared package mips16_ctx_pkg: state enum ctx_state_t, constants NUM_REGS, SAVE_BEATS=4, CS_PAD=16'h0000.
- Single module; no sub-module. The checksum XOR is inline.

Test Plan:
- Preload R0..R7 = 16'h1000+i; pulse save_req, sv_ready=1 -> 5 beats: 32'h1001_1000, 32'h1003_1002, 32'h1005_1004, 32'h1007_1006, 32'h0000_0000 (XOR); done after beat 5.
- Restore words 16'hA000..16'hA007 plus checksum 16'h0000, rs_valid=1 every cycle -> R[i]=16'hA000+i; done=1, cs_err=0; reads back correctly.
- Same restore with checksum word 16'hFFFF -> all registers written, done=1 with cs_err=1.
- Save with sv_ready toggled 1/0 every cycle -> sv_data stable while stalled; identical beat sequence; no duplicate or skipped beat.
- Restore with rs_valid gaps; assert rst after the 3rd word -> R0..R2 updated, R3..R7 unchanged; busy=0, no done pulse; a following save_req works normally.
- save_req and restore_req high together in IDLE -> save executes, reg_write_en never asserts; restore_req asserted mid-save is ignored.
